// File: rtl/rfid_cmd_tx_pkg.sv
// Shared constants, sequencer state encoding and baud divisor helper for rfid_cmd_tx.
// Latency: n/a (declarations only). Backpressure: n/a.
package rfid_cmd_tx_pkg;

    localparam logic [7:0] SOF      = 8'hAA;
    localparam logic [7:0] EOF      = 8'hBB;
    localparam int         MAX_PLEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_e;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rfid_cmd_tx_if.sv
// Command request / serial status bundle between the control FSM and rfid_cmd_tx.
// Latency: n/a. Backpressure: start is only honoured while busy is low.
interface rfid_cmd_tx_if;

    logic        start;
    logic [7:0]  cmd;
    logic [31:0] payload;
    logic [2:0]  plen;
    logic        TX;
    logic        busy;
    logic        done;

    modport master (
        output start, cmd, payload, plen,
        input  TX, busy, done
    );

    modport slave (
        input  start, cmd, payload, plen,
        output TX, busy, done
    );

endinterface

// File: rtl/rfid_cmd_tx_uart_tx_byte.sv
// 8N1 byte serialiser with a one-byte holding slot so consecutive bytes leave with no gap.
// Latency: start bit on TX the edge after load. Backpressure: at most one byte may wait behind the one shifting.
module uart_tx_byte #(
    parameter int DIV = 5208
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       bdone
);

    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    logic        active_q,   active_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_dat_q, pend_dat_d;
    logic [9:0]  shreg_q,    shreg_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic        tick;

    assign tick = active_q && (baud_cnt_q == DIV_M1);
    assign tx   = shreg_q[0];

    always_comb begin
        active_d   = active_q;
        pend_vld_d = pend_vld_q;
        pend_dat_d = pend_dat_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        bdone      = tick && (bit_cnt_q == 4'd9);

        if (active_q) begin
            baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
            if (tick) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                shreg_d   = {1'b1, shreg_q[9:1]};
                if (bit_cnt_q == 4'd9) begin
                    bit_cnt_d = 4'd0;
                    // Held byte starts on the very edge the stop bit ends.
                    if (pend_vld_q) begin
                        shreg_d    = {1'b1, pend_dat_q, 1'b0};
                        pend_vld_d = 1'b0;
                    end else begin
                        active_d = 1'b0;
                    end
                end
            end
        end

        if (load) begin
            if (!active_q || (bdone && !pend_vld_q)) begin
                shreg_d    = {1'b1, data, 1'b0};
                active_d   = 1'b1;
                bit_cnt_d  = 4'd0;
                baud_cnt_d = 16'd0;
            end else begin
                pend_vld_d = 1'b1;
                pend_dat_d = data;
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            active_q   <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= 8'd0;
            shreg_q    <= 10'h3FF;
            bit_cnt_q  <= 4'd0;
            baud_cnt_q <= 16'd0;
        end else begin
            active_q   <= active_d;
            pend_vld_q <= pend_vld_d;
            pend_dat_q <= pend_dat_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
        end
    end

endmodule

// File: rtl/rfid_cmd_tx.sv
// Frames cmd + 0..4 payload bytes (SOF LEN CMD PAY.. CHK EOF) and sends them 8N1 on TX.
// Latency: SOF start bit two cycles after start is accepted. Backpressure: start ignored while busy or done.
module rfid_cmd_tx
    import rfid_cmd_tx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic         clk,
    input  logic         RST,
    rfid_cmd_tx_if.slave bus
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    if (DIV < 2) begin : g_div_chk
        $error("rfid_cmd_tx: CLK_HZ/BAUD must be at least 2");
    end

    state_e      state_q,    state_d;
    logic [3:0]  idx_q,      idx_d;
    logic [3:0]  last_q,     last_d;
    logic [7:0]  cmd_q,      cmd_d;
    logic [31:0] pay_q,      pay_d;
    logic [2:0]  plen_q,     plen_d;
    logic [7:0]  chk_q,      chk_d;
    logic [7:0]  byte_q,     byte_d;
    logic [1:0]  inflight_q, inflight_d;

    logic        ser_load;
    logic        bdone;
    logic        ser_tx;
    logic [2:0]  plen_eff;
    logic [1:0]  pay_k;
    logic [7:0]  cur_byte;
    logic        chk_add;

    assign plen_eff = (bus.plen > 3'(MAX_PLEN)) ? 3'(MAX_PLEN) : bus.plen;
    assign pay_k    = 2'(idx_q - 4'd3);
    // LEN, cmd and payload sit strictly between SOF and the CHK slot.
    assign chk_add  = (idx_q != 4'd0) && (idx_q < (last_q - 4'd1));

    always_comb begin
        cur_byte = 8'd0;
        if (idx_q == 4'd0) begin
            cur_byte = SOF;
        end else if (idx_q == 4'd1) begin
            cur_byte = {5'd0, plen_q} + 8'd1;
        end else if (idx_q == 4'd2) begin
            cur_byte = cmd_q;
        end else if (idx_q == last_q) begin
            cur_byte = EOF;
        end else if (idx_q == (last_q - 4'd1)) begin
            cur_byte = chk_q;
        end else begin
            case (pay_k)
                2'd0:    cur_byte = pay_q[31:24];
                2'd1:    cur_byte = pay_q[23:16];
                2'd2:    cur_byte = pay_q[15:8];
                default: cur_byte = pay_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        cmd_d    = cmd_q;
        pay_d    = pay_q;
        plen_d   = plen_q;
        chk_d    = chk_q;
        byte_d   = byte_q;
        ser_load = 1'b0;

        case (state_q)
            IDLE: begin
                chk_d = 8'd0;
                idx_d = 4'd0;
                if (bus.start) begin
                    cmd_d   = bus.cmd;
                    pay_d   = bus.payload;
                    plen_d  = plen_eff;
                    last_d  = {1'b0, plen_eff} + 4'd4;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                byte_d = cur_byte;
                if (chk_add) begin
                    chk_d = chk_q ^ cur_byte;
                end
                state_d = SEND;
            end
            SEND: begin
                ser_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // Stay one byte ahead of the serialiser; finish when its last byte drains.
                if (idx_q < last_q) begin
                    if ((inflight_q < 2'd2) || bdone) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = LOAD;
                    end
                end else if (bdone && (inflight_q == 2'd1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inflight_d = inflight_q + {1'b0, ser_load} - {1'b0, bdone};
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            last_q     <= 4'd0;
            cmd_q      <= 8'd0;
            pay_q      <= 32'd0;
            plen_q     <= 3'd0;
            chk_q      <= 8'd0;
            byte_q     <= 8'd0;
            inflight_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            cmd_q      <= cmd_d;
            pay_q      <= pay_d;
            plen_q     <= plen_d;
            chk_q      <= chk_d;
            byte_q     <= byte_d;
            inflight_q <= inflight_d;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_uart_tx_byte (
        .clk   (clk),
        .RST   (RST),
        .load  (ser_load),
        .data  (byte_q),
        .tx    (ser_tx),
        .bdone (bdone)
    );

    assign bus.TX   = ser_tx;
    assign bus.busy = (state_q == LOAD) || (state_q == SEND) || (state_q == WAIT);
    assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_rfid_cmd_tx.sv
// Directed bench for rfid_cmd_tx at DIV=16: frame content, bit timing, busy/done and reset.
module tb_rfid_cmd_tx;

    localparam int BIT_CYC  = 16;
    localparam int BYTE_CYC = 10 * BIT_CYC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rfid_cmd_tx_if bus_if();

    rfid_cmd_tx #(
        .CLK_HZ (16),
        .BAUD   (1)
    ) dut (
        .clk (clk),
        .RST (rst_n),
        .bus (bus_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n0    = 0;
    logic [7:0] exp_b [0:8];
    int exp_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] c, input logic [31:0] p, input logic [2:0] l, input bit hold);
        bus_if.cmd     = c;
        bus_if.payload = p;
        bus_if.plen    = l;
        bus_if.start   = 1'b1;
        tick();
        n0 = cyc;
        if (!hold) bus_if.start = 1'b0;
    endtask

    task automatic set_min_frame();
        exp_n = 5;
        exp_b[0] = 8'hAA; exp_b[1] = 8'h01; exp_b[2] = 8'h01; exp_b[3] = 8'h00; exp_b[4] = 8'hBB;
    endtask

    task automatic set_max_frame();
        exp_n = 9;
        exp_b[0] = 8'hAA; exp_b[1] = 8'h05; exp_b[2] = 8'h20; exp_b[3] = 8'h12; exp_b[4] = 8'h34;
        exp_b[5] = 8'h56; exp_b[6] = 8'h78; exp_b[7] = 8'h2D; exp_b[8] = 8'hBB;
    endtask

    // Walks the frame cycle by cycle from the accept edge, checking TX level, busy and done
    // against the ideal waveform; optionally pulses start with a different command at inj_rel.
    task automatic run_frame(input string nm, input int inj_rel);
        int fl;
        int e;
        int k;
        int bi;
        int bb;
        logic tx_e;
        int wave_err;
        int busy_err;
        int done_err;
        logic [7:0] rx [0:8];
        fl = exp_n * BYTE_CYC;
        e  = 2 + fl;
        wave_err = 0;
        busy_err = 0;
        done_err = 0;
        for (int r = 0; r <= e + 1; r++) begin
            if (r > 0) tick();
            tx_e = 1'b1;
            if (r >= 2 && (r - 2) < fl) begin
                k  = r - 2;
                bi = k / BYTE_CYC;
                bb = (k % BYTE_CYC) / BIT_CYC;
                if (bb == 0) tx_e = 1'b0;
                else if (bb == 9) tx_e = 1'b1;
                else tx_e = exp_b[bi][bb-1];
                if ((k % BIT_CYC) == BIT_CYC / 2 && bb >= 1 && bb <= 8) rx[bi][bb-1] = bus_if.TX;
            end
            if (bus_if.TX !== tx_e) wave_err++;
            if (bus_if.busy !== (r < e)) busy_err++;
            if (bus_if.done !== (r == e)) done_err++;
            if (r == inj_rel) begin
                bus_if.cmd     = 8'h55;
                bus_if.payload = 32'hC300_0000;
                bus_if.plen    = 3'd1;
                bus_if.start   = 1'b1;
            end
            if (inj_rel >= 0 && r == inj_rel + 1) bus_if.start = 1'b0;
        end
        for (int i = 0; i < exp_n; i++) begin
            n_cmp++;
            if (rx[i] !== exp_b[i]) begin
                n_err++;
                $display("FAIL %s byte%0d: got %h expected %h", nm, i, rx[i], exp_b[i]);
            end
        end
        n_cmp++;
        if (wave_err !== 0) begin
            n_err++;
            $display("FAIL %s tx_timing: %0d bad cycles, expected 0", nm, wave_err);
        end
        n_cmp++;
        if (busy_err !== 0) begin
            n_err++;
            $display("FAIL %s busy_window: %0d bad cycles, expected busy for %0d cycles", nm, busy_err, e);
        end
        n_cmp++;
        if (done_err !== 0) begin
            n_err++;
            $display("FAIL %s done_pulse: %0d bad cycles, expected single pulse at N+%0d", nm, done_err, e);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (bus_if.TX !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b expected 1", bus_if.TX); end
        n_cmp++;
        if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
        n_cmp++;
        if (bus_if.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus_if.done); end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_min_frame();
        set_min_frame();
        launch(8'h01, 32'h0, 3'd0, 1'b0);
        run_frame("min_frame", -1);
        repeat (2) tick();
    endtask

    task automatic test_max_frame();
        set_max_frame();
        launch(8'h20, 32'h1234_5678, 3'd4, 1'b0);
        run_frame("max_frame", -1);
        repeat (2) tick();
    endtask

    task automatic test_plen_clamp();
        set_max_frame();
        launch(8'h20, 32'h1234_5678, 3'd7, 1'b0);
        run_frame("plen_clamp", -1);
        repeat (2) tick();
    endtask

    task automatic test_ignore_busy_start();
        set_min_frame();
        launch(8'h01, 32'h0, 3'd0, 1'b0);
        run_frame("busy_start_first", 100);
        tick();
        exp_n = 6;
        exp_b[0] = 8'hAA; exp_b[1] = 8'h02; exp_b[2] = 8'h55;
        exp_b[3] = 8'hC3; exp_b[4] = 8'h94; exp_b[5] = 8'hBB;
        launch(8'h55, 32'hC300_0000, 3'd1, 1'b0);
        run_frame("busy_start_second", -1);
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_frame();
        int stray;
        set_max_frame();
        launch(8'h20, 32'h1234_5678, 3'd4, 1'b0);
        repeat (300) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_if.TX !== 1'b1) begin n_err++; $display("FAIL midrst_tx: got %b expected 1", bus_if.TX); end
        n_cmp++;
        if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", bus_if.busy); end
        stray = 0;
        repeat (3) begin
            tick();
            if (bus_if.done !== 1'b0 || bus_if.TX !== 1'b1) stray++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            tick();
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.TX !== 1'b1) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin n_err++; $display("FAIL midrst_quiet: %0d active cycles, expected 0", stray); end
        launch(8'h20, 32'h1234_5678, 3'd4, 1'b0);
        run_frame("after_reset", -1);
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int idle_busy;
        set_min_frame();
        launch(8'h01, 32'h0, 3'd0, 1'b1);
        run_frame("b2b_first", -1);
        tick();
        n_cmp++;
        if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL b2b_relaunch: busy got %b expected 1", bus_if.busy); end
        n0 = cyc;
        run_frame("b2b_second", -1);
        bus_if.start = 1'b0;
        idle_busy = 0;
        repeat (5) begin
            tick();
            if (bus_if.busy !== 1'b0) idle_busy++;
        end
        n_cmp++;
        if (idle_busy !== 0) begin n_err++; $display("FAIL b2b_stop: busy %0d cycles after release, expected 0", idle_busy); end
    endtask

    initial begin
        bus_if.start   = 1'b0;
        bus_if.cmd     = 8'h00;
        bus_if.payload = 32'h0;
        bus_if.plen    = 3'd0;
        test_reset();
        test_min_frame();
        test_max_frame();
        test_plen_clamp();
        test_ignore_busy_start();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
